// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-addressed data memory: access-size encodings
// and the fixed data-port width.
package data_memory_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_LANES  = DMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        RW_WORD    = 2'b00,
        RW_HALF    = 2'b01,
        RW_BYTE    = 2'b10,
        RW_INVALID = 2'b11
    } rw_mode_e;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Little-endian byte-array data memory with word/halfword/byte access,
// combinational reads, clocked writes, and an immediate asynchronous clear.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DMEM_DATA_WIDTH = DMEM_DATA_W,
    parameter int DMEM_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [1:0]                 rw_mode,
    input  logic [DMEM_ADDR_WIDTH-1:0] addr,
    input  logic [DMEM_DATA_WIDTH-1:0] w_data,
    output logic [DMEM_DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << DMEM_ADDR_WIDTH;

    logic [7:0]                 mem [DEPTH];
    logic [2:0]                 n_bytes;
    logic                       aligned;
    logic [DMEM_ADDR_WIDTH:0]   last_addr;
    logic                       valid;
    logic [DMEM_LANES-1:0]      lane_en;
    logic [DMEM_ADDR_WIDTH-1:0] lane_addr [DMEM_LANES];

    // Access decode: size, alignment, capacity check and per-lane enables.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        n_bytes = 3'd0;
        aligned = 1'b0;
        case (rw_mode_e'(rw_mode))
            RW_WORD: begin
                n_bytes = 3'd4;
                aligned = (addr[1:0] == 2'b00);
            end
            RW_HALF: begin
                n_bytes = 3'd2;
                aligned = ~addr[0];
            end
            RW_BYTE: begin
                n_bytes = 3'd1;
                aligned = 1'b1;
            end
            default: begin
                n_bytes = 3'd0;
                aligned = 1'b0;
            end
        endcase

        // The extra top bit of last_addr flags an access running past the end.
        last_addr = {1'b0, addr} + (DMEM_ADDR_WIDTH+1)'(n_bytes) - (DMEM_ADDR_WIDTH+1)'(1);
        valid     = (n_bytes != 3'd0) && aligned && ~last_addr[DMEM_ADDR_WIDTH];

        lane_en = '0;
        for (int i = 0; i < DMEM_LANES; i++) begin
            lane_addr[i] = addr + DMEM_ADDR_WIDTH'(i);
            if (valid && (3'(i) < n_bytes))
                lane_en[i] = 1'b1;
        end
    end

    // Zero-latency read; disabled lanes stay zero, which gives zero-extension.
    always_comb begin
        r_data = '0;
        for (int i = 0; i < DMEM_LANES; i++) begin
            if (lane_en[i] && !rst)
                r_data[8*i +: 8] = mem[lane_addr[i]];
        end
    end

    // NOTE: the storage array is reset asynchronously because contents must clear
    // the moment rst rises; this deliberately builds it from flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                mem[j] <= 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < DMEM_LANES; i++) begin
                if (lane_en[i])
                    mem[lane_addr[i]] <= w_data[8*i +: 8];
            end
        end
    end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset, sized writes and reads,
// misalignment, invalid mode, read-before-write and asynchronous clear.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  rw_mode;
    logic [3:0]  addr;
    logic [31:0] w_data;
    logic [31:0] r_data;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] M_WORD = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_BYTE = 2'b10;
    localparam logic [1:0] M_INV  = 2'b11;

    data_memory #(
        .DMEM_DATA_WIDTH(32),
        .DMEM_ADDR_WIDTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .rw_mode(rw_mode),
        .addr   (addr),
        .w_data (w_data),
        .r_data (r_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] expected);
        checks++;
        assert (r_data === expected)
        else begin
            failures++;
            $error("FAIL %s: r_data=0x%08h expected=0x%08h", tag, r_data, expected);
        end
    endtask

    // Read is combinational: apply inputs mid-cycle and sample 1 ns later.
    task automatic rd(input string tag, input logic [1:0] mode, input logic [3:0] a,
                      input logic [31:0] expected);
        @(negedge clk);
        wr_en   = 1'b0;
        rw_mode = mode;
        addr    = a;
        #1;
        check(tag, expected);
    endtask

    task automatic wr(input logic [1:0] mode, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        rw_mode = mode;
        addr    = a;
        w_data  = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rw_mode = M_WORD;
        addr    = 4'd0;
        w_data  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        rd("reset_w0",  M_WORD, 4'd0,  32'h0000_0000);
        rd("reset_w4",  M_WORD, 4'd4,  32'h0000_0000);
        rd("reset_w8",  M_WORD, 4'd8,  32'h0000_0000);
        rd("reset_w12", M_WORD, 4'd12, 32'h0000_0000);

        wr(M_BYTE, 4'd5, 32'd15);
        rd("byte_wr5_w4", M_WORD, 4'd4, 32'h0000_0F00);

        wr(M_HALF, 4'd7, 32'h1B18_1512);
        rd("half_mis7_w4", M_WORD, 4'd4, 32'h0000_0F00);
        rd("half_mis7_w8", M_WORD, 4'd8, 32'h0000_0000);

        wr(M_HALF, 4'd6, 32'h1B18_1512);
        rd("half_wr6_w4", M_WORD, 4'd4, 32'h1512_0F00);
        rd("half_rd6",    M_HALF, 4'd6, 32'h0000_1512);
        rd("byte_rd5",    M_BYTE, 4'd5, 32'h0000_000F);

        wr(M_WORD, 4'd6, 32'h211E_1B18);
        rd("word_mis6_w0", M_WORD, 4'd0, 32'h0000_0000);
        rd("word_mis6_w4", M_WORD, 4'd4, 32'h1512_0F00);
        rd("word_mis6_w8", M_WORD, 4'd8, 32'h0000_0000);

        // Read-before-write: old contents visible until the write edge.
        @(negedge clk);
        wr_en   = 1'b1;
        rw_mode = M_WORD;
        addr    = 4'd8;
        w_data  = 32'h211E_1B18;
        #1;
        check("rbw_before_edge", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rbw_after_edge", 32'h211E_1B18);
        wr_en = 1'b0;

        rd("word_rd8",  M_WORD, 4'd8,  32'h211E_1B18);
        rd("byte_rd11", M_BYTE, 4'd11, 32'h0000_0021);
        rd("byte_rd9",  M_BYTE, 4'd9,  32'h0000_001B);
        rd("half_rd10", M_HALF, 4'd10, 32'h0000_211E);
        rd("half_mis5", M_HALF, 4'd5,  32'h0000_0000);
        rd("word_mis2", M_WORD, 4'd2,  32'h0000_0000);

        wr(M_BYTE, 4'd15, 32'h0000_00AB);
        rd("byte_top_w12", M_WORD, 4'd12, 32'hAB00_0000);

        rd("inv_rd4", M_INV, 4'd4, 32'h0000_0000);
        rd("inv_rd8", M_INV, 4'd8, 32'h0000_0000);
        wr(M_INV, 4'd4, 32'hFFFF_FFFF);
        rd("inv_wr_w4", M_WORD, 4'd4, 32'h1512_0F00);
        rd("inv_wr_w8", M_WORD, 4'd8, 32'h211E_1B18);

        // Asynchronous clear between edges, observed before the next rising edge.
        @(negedge clk);
        rw_mode = M_WORD;
        addr    = 4'd4;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_w4", 32'h0000_0000);
        addr = 4'd8;
        #1;
        check("async_rst_w8", 32'h0000_0000);

        // Writes are ignored while reset is held.
        wr_en  = 1'b1;
        addr   = 4'd0;
        w_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("rst_hold_w0", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        rd("post_rst_w0",  M_WORD, 4'd0,  32'h0000_0000);
        rd("post_rst_w12", M_WORD, 4'd12, 32'h0000_0000);

        wr(M_WORD, 4'd0, 32'hCAFE_F00D);
        rd("resume_w0", M_WORD, 4'd0, 32'hCAFE_F00D);
        rd("resume_h2", M_HALF, 4'd2, 32'h0000_CAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_memory

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DMEM_DATA_WIDTH, default 32, data port width; only 32 is supported.
REQ-002 Parameter DMEM_ADDR_WIDTH, default 4, byte-address width; capacity is 2^DMEM_ADDR_WIDTH bytes.
REQ-003 clk  input  1  sole clock; all writes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  1 = write access this cycle, 0 = read only.
REQ-006 rw_mode  input  2  access size: 00 word, 01 halfword, 10 byte, 11 invalid.
REQ-007 addr  input  DMEM_ADDR_WIDTH  byte address of the access.
REQ-008 w_data  input  DMEM_DATA_WIDTH  write data; byte uses [7:0], halfword uses [15:0], word uses [31:0].
REQ-009 r_data  output  DMEM_DATA_WIDTH  read data.

Function
REQ-010 The storage SHALL be a byte array of 2^DMEM_ADDR_WIDTH entries with little-endian lane order: the lowest address holds the least-significant byte.
REQ-011 Alignment SHALL be: word needs addr[1:0]==00; halfword needs addr[0]==0; byte is always aligned.
REQ-012 Access validity SHALL require rw_mode!=11, alignment met, and the last accessed byte within capacity.
REQ-013 Reads SHALL be combinational from addr, rw_mode and the current contents, with zero latency.
REQ-014 A valid read SHALL zero-extend byte and halfword values into r_data.
REQ-015 An invalid read SHALL drive r_data = 0.
REQ-016 A valid write with wr_en=1 SHALL update exactly the addressed 1/2/4 bytes at the rising clk edge.
REQ-017 All other bytes SHALL be unchanged by a write.
REQ-018 An invalid access with wr_en=1 SHALL leave memory unchanged; no error output is provided.
REQ-019 r_data SHALL show the newly written value only after the write edge (read-before-write within a cycle).
REQ-020 There SHALL be no handshake; every cycle is an independent access.

Reset
REQ-021 While rst=1, all memory bytes SHALL be cleared to 0 immediately, independent of clk.
REQ-022 While rst=1, r_data SHALL read 0 and writes SHALL be ignored.
REQ-023 Asserting rst mid-sequence SHALL discard all prior contents.
REQ-024 Operation SHALL resume on the first rising clk edge after rst deasserts.

Structure
REQ-025 A shared package SHALL hold the rw_mode encodings (WORD=00, HALF=01, BYTE=10) and the data width of 32.
REQ-026 The block SHALL be a single module with no sub-modules.
REQ-027 Alignment/validity decode and byte-lane enables SHALL be combinational logic inside the module.

Verification
REQ-028 Reset: pulse rst; word read at addr 0, 4, 8, 12 -> r_data 0x00000000 for each.
REQ-029 Byte write: wr_en=1, mode 10, addr 5, w_data 15, one edge; word read at addr 4 -> 0x00000F00.
REQ-030 Halfword writes: mode 01, w_data 0x1B181512.
- At addr 7 (misaligned): word at 4 still reads 0x00000F00.
- At addr 6: word at 4 reads 0x15120F00.
- Halfword read at addr 6 reads 0x00001512.
REQ-031 Word writes: mode 00, w_data 0x211E1B18.
- At addr 6 (misaligned): no change anywhere.
- At addr 8: word at 8 reads 0x211E1B18.
- Byte read at addr 11 reads 0x00000021.
REQ-032 Invalid mode: mode 11 with any addr -> r_data 0; mode 11 with wr_en=1 -> all contents unchanged.
REQ-033 Reset after writes: rst asserted between clock edges -> word at 4 and word at 8 read 0 immediately, before the next clk edge.
